stepper_pulse_gen: RTL and testbench

Parametrised, command-driven STEP/DIR pulse generator for one stepper driver channel on the 50 MHz fabric clock. It accepts a move command (step count, direction, half-period) through a valid/ready handshake and enforces driver setup and minimum pulse-width timing. It emits exactly the commanded number of pulses and tracks absolute position. It supports pause and abort, and sits between the motion sequencer and the driver IO pins; one instance is used per axis.

---
 rtl/stepper_pkg.sv | 10 +
 rtl/stepper_pulse_gen_phase_timer.sv | 33 +++
 rtl/stepper_pulse_gen.sv | 167 ++++++++++++++++
 tb/tb_stepper_pulse_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared types and default timing constants for the STEP/DIR pulse generator.
package stepper_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} step_state_t;

  localparam int CLK_HZ        = 50_000_000;
  localparam int DEF_SETUP_CYC = 10;
  localparam int DEF_MIN_HALF  = 50;

endpackage

// File: rtl/stepper_pulse_gen_phase_timer.sv
// Loadable down-counter that times the SETUP, HIGH and LOW phases.
// o_zero is registered alongside the count, so it is valid from the cycle after a load.
module phase_timer #(
  parameter int PER_W = 16
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             i_load,
  input  logic [PER_W-1:0] i_load_val,
  input  logic             i_count_en,
  output logic             o_zero
);

  logic [PER_W-1:0] r_count;
  logic             r_zero;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_zero  <= 1'b1;
    end else if (i_load) begin
      r_count <= i_load_val;
      r_zero  <= (i_load_val == '0);
    end else if (i_count_en && !r_zero) begin
      r_count <= r_count - PER_W'(1);
      r_zero  <= (r_count == PER_W'(1));
    end
  end

  assign o_zero = r_zero;

endmodule

// File: rtl/stepper_pulse_gen.sv
// Command-driven STEP/DIR pulse generator for one stepper axis: enforces DIR setup and
// minimum pulse width, counts remaining pulses and tracks signed absolute position.
module stepper_pulse_gen
  import stepper_pkg::*;
#(
  parameter int STEP_W    = 16,
  parameter int PER_W     = 16,
  parameter int POS_W     = 24,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int MIN_HALF  = DEF_MIN_HALF
) (
  input  logic                    clk_50,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [STEP_W-1:0]       cmd_steps,
  input  logic                    cmd_dir,
  input  logic [PER_W-1:0]        cmd_half_period,
  input  logic                    enable,
  input  logic                    abort,
  output logic                    step,
  output logic                    dir,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [STEP_W-1:0]       steps_left,
  output logic signed [POS_W-1:0] position
);

  step_state_t              r_state;
  step_state_t              w_next_state;
  logic [PER_W-1:0]         r_half;
  logic [PER_W-1:0]         w_half_clamped;
  logic [PER_W-1:0]         w_tmr_val;
  logic                     w_tmr_load;
  logic                     w_tmr_en;
  logic                     w_tmr_zero;
  logic                     w_timed;
  logic                     w_run;
  logic                     w_accept;
  logic                     w_abort_req;
  logic                     w_phase_end;
  logic                     r_abort_pend;
  logic                     r_step;
  logic                     r_dir;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_aborted;
  logic [STEP_W-1:0]        r_steps_left;
  logic signed [POS_W-1:0]  r_position;

  assign w_half_clamped = (cmd_half_period < PER_W'(MIN_HALF)) ? PER_W'(MIN_HALF) : cmd_half_period;
  assign w_accept       = cmd_valid && (r_state == IDLE);
  assign w_abort_req    = r_abort_pend || abort;
  assign w_timed        = (r_state == SETUP) || (r_state == HIGH) || (r_state == LOW);
  // A pending abort keeps the timers running even while paused.
  assign w_run          = enable || w_abort_req;
  assign w_tmr_en       = w_timed && w_run;
  assign w_phase_end    = w_tmr_en && w_tmr_zero;

  phase_timer #(.PER_W(PER_W)) u_timer (
    .clk_50     (clk_50),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_count_en (w_tmr_en),
    .o_zero     (w_tmr_zero)
  );

  // Timers are loaded with length-1 so each phase lasts exactly its length in cycles.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_tmr_load   = 1'b0;
    w_tmr_val    = r_half - PER_W'(1);
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = SETUP;
          w_tmr_load   = 1'b1;
          w_tmr_val    = PER_W'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (w_abort_req) begin
          w_next_state = DONE;
        end else if (w_phase_end) begin
          if (r_steps_left != '0) begin
            w_next_state = HIGH;
            w_tmr_load   = 1'b1;
          end else begin
            w_next_state = DONE;
          end
        end
      end
      HIGH: begin
        if (w_phase_end) begin
          w_next_state = LOW;
          w_tmr_load   = 1'b1;
        end
      end
      LOW: begin
        if (w_phase_end) begin
          if ((r_steps_left != '0) && !w_abort_req) begin
            w_next_state = HIGH;
            w_tmr_load   = 1'b1;
          end else begin
            w_next_state = DONE;
          end
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_half       <= '0;
      r_abort_pend <= 1'b0;
      r_step       <= 1'b0;
      r_dir        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_steps_left <= '0;
      r_position   <= '0;
    end else begin
      r_state <= w_next_state;
      r_step  <= (w_next_state == HIGH);
      r_done  <= (w_next_state == DONE);
      r_busy  <= (w_next_state != IDLE);

      if (w_accept) begin
        r_dir        <= cmd_dir;
        r_steps_left <= cmd_steps;
        r_half       <= w_half_clamped;
        r_aborted    <= 1'b0;
      end

      if ((r_state != HIGH) && (w_next_state == HIGH)) begin
        r_position <= r_dir ? r_position + POS_W'(1) : r_position - POS_W'(1);
      end
      if ((r_state == HIGH) && (w_next_state == LOW)) begin
        r_steps_left <= r_steps_left - STEP_W'(1);
      end

      if (r_state == DONE) begin
        if (r_abort_pend) r_aborted <= 1'b1;
        r_abort_pend <= 1'b0;
      end else if (w_timed && abort) begin
        r_abort_pend <= 1'b1;
      end
    end
  end

  assign cmd_ready  = (r_state == IDLE);
  assign step       = r_step;
  assign dir        = r_dir;
  assign busy       = r_busy;
  assign done       = r_done;
  assign aborted    = r_aborted;
  assign steps_left = r_steps_left;
  assign position   = r_position;

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Scoreboard bench for stepper_pulse_gen: stimulus queues expected per-move results,
// a negedge monitor measures each move and compares when done is seen.
`timescale 1ns/1ps
module tb_stepper_pulse_gen;

  localparam int STEP_W = 16;
  localparam int PER_W  = 16;
  localparam int POS_W  = 24;

  logic                    clk_50 = 1'b0;
  logic                    reset  = 1'b1;
  logic                    cmd_valid = 1'b0;
  logic                    cmd_ready;
  logic [STEP_W-1:0]       cmd_steps = '0;
  logic                    cmd_dir = 1'b0;
  logic [PER_W-1:0]        cmd_half_period = '0;
  logic                    enable = 1'b1;
  logic                    abort = 1'b0;
  logic                    step, dir, busy, done, aborted;
  logic [STEP_W-1:0]       steps_left;
  logic signed [POS_W-1:0] position;

  always #10 clk_50 = ~clk_50;

  stepper_pulse_gen #(
    .STEP_W(STEP_W), .PER_W(PER_W), .POS_W(POS_W), .SETUP_CYC(10), .MIN_HALF(50)
  ) dut (
    .clk_50(clk_50), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_half_period(cmd_half_period),
    .enable(enable), .abort(abort), .step(step), .dir(dir), .busy(busy), .done(done),
    .aborted(aborted), .steps_left(steps_left), .position(position)
  );

  // Cycle 1 is the first cycle after the accept edge; gap is cycles from done to next accept.
  typedef struct {
    int first_rise;
    int pulses;
    int hi_min;
    int hi_max;
    int done_cyc;
    int steps_left;
    int position;
    int aborted;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int fr, input int np, input int hmin, input int hmax,
                          input int dc, input int sl, input int pos, input int ab, input int gap);
    exp_t e;
    e = '{fr, np, hmin, hmax, dc, sl, pos, ab, gap};
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  int m_cyc, m_first, m_pulses, m_hirun, m_himin, m_himax, m_gap;
  int m_done_cyc, m_sl, m_pos;
  int m_since_done = 1000;
  bit m_in, m_prev, m_pend;

  always @(negedge clk_50) begin
    exp_t e;
    if (reset) begin
      m_in   = 1'b0;
      m_pend = 1'b0;
      m_prev = 1'b0;
    end else begin
      if (m_pend) begin
        m_pend = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("first_rise_cycle", m_first, e.first_rise);
          check("pulse_count", m_pulses, e.pulses);
          check("high_min", m_himin, e.hi_min);
          check("high_max", m_himax, e.hi_max);
          check("done_cycle", m_done_cyc, e.done_cyc);
          check("steps_left_at_done", m_sl, e.steps_left);
          check("position_at_done", m_pos, e.position);
          check("aborted_after_done", int'(aborted), e.aborted);
          if (e.gap >= 0) check("reaccept_gap", m_gap, e.gap);
        end
      end
      m_since_done++;
      if (m_in) begin
        m_cyc++;
        if (step) begin
          m_hirun++;
          if (!m_prev) begin
            m_pulses++;
            if (m_first < 0) m_first = m_cyc;
          end
        end else if (m_prev) begin
          if (m_himax == 0 || m_hirun < m_himin) m_himin = m_hirun;
          if (m_hirun > m_himax) m_himax = m_hirun;
          m_hirun = 0;
        end
        m_prev = step;
        if (done) begin
          m_done_cyc   = m_cyc;
          m_sl         = int'(steps_left);
          m_pos        = int'(position);
          m_pend       = 1'b1;
          m_in         = 1'b0;
          m_since_done = 0;
        end
      end else if (done) begin
        check("done_outside_move", 1, 0);
      end
      if (cmd_valid && cmd_ready) begin
        m_in     = 1'b1;
        m_cyc    = 0;
        m_first  = -1;
        m_pulses = 0;
        m_hirun  = 0;
        m_himin  = 0;
        m_himax  = 0;
        m_prev   = 1'b0;
        m_gap    = m_since_done;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_cmd(input int n, input bit d, input int half);
    int budget;
    bit acc;
    cmd_steps       = STEP_W'(n);
    cmd_dir         = d;
    cmd_half_period = PER_W'(half);
    cmd_valid       = 1'b1;
    acc    = 1'b0;
    budget = 50;
    while (!acc && budget > 0) begin
      @(negedge clk_50);
      acc = cmd_ready;
      @(posedge clk_50);
      #1;
      budget--;
    end
    cmd_valid = 1'b0;
    check("cmd_accepted", int'(acc), 1);
  endtask

  task automatic wait_idle(input int budget);
    int b;
    b = budget;
    do begin
      @(negedge clk_50);
      b--;
    end while (busy && b > 0);
    check("move_ends_in_budget", int'(busy), 0);
    repeat (2) @(posedge clk_50);
    #1;
  endtask

  task automatic wait_step(input bit level, input int budget);
    int b;
    b = budget;
    do begin
      @(negedge clk_50);
      b--;
    end while (step !== level && b > 0);
    check("step_reaches_level", int'(step), int'(level));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_step"}, int'(step), 0);
    check({tag, "_dir"}, int'(dir), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_aborted"}, int'(aborted), 0);
    check({tag, "_steps_left"}, int'(steps_left), 0);
    check({tag, "_position"}, int'(position), 0);
    check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n_acc;
    int budget;

    repeat (3) @(posedge clk_50);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;
    repeat (2) @(posedge clk_50);
    #1;

    // 3 steps up at H=60: done at 11 + 2*60*3
    push_exp(11, 3, 60, 60, 371, 0, 3, 0, -1);
    send_cmd(3, 1'b1, 60);
    wait_idle(1000);

    // half-period 5 clamps to 50; then 2 steps down for a net +1 over the pair
    push_exp(11, 3, 50, 50, 311, 0, 6, 0, -1);
    send_cmd(3, 1'b1, 5);
    wait_idle(1000);
    push_exp(11, 2, 50, 50, 211, 0, 4, 0, -1);
    send_cmd(2, 1'b0, 50);
    wait_idle(1000);

    // pause 37 cycles inside the first HIGH: that pulse is 97 high, move 37 cycles longer
    push_exp(11, 2, 60, 97, 288, 0, 6, 0, -1);
    send_cmd(2, 1'b1, 60);
    wait_step(1'b1, 50);
    repeat (20) @(posedge clk_50);
    #1 enable = 1'b0;
    repeat (37) @(posedge clk_50);
    #1 enable = 1'b1;
    wait_idle(1000);

    // abort in the 20th HIGH cycle of a 10-step move: one pulse, full LOW, then done
    push_exp(11, 1, 60, 60, 131, 9, 7, 1, -1);
    send_cmd(10, 1'b1, 60);
    wait_step(1'b1, 50);
    repeat (19) @(posedge clk_50);
    #1 abort = 1'b1;
    @(posedge clk_50);
    #1 abort = 1'b0;
    wait_idle(1000);
    check("aborted_held_in_idle", int'(aborted), 1);

    // zero-step commands with cmd_valid held: second accept the cycle after done
    push_exp(-1, 0, 0, 0, 11, 0, 7, 0, -1);
    push_exp(-1, 0, 0, 0, 11, 0, 7, 0, 1);
    cmd_steps       = '0;
    cmd_dir         = 1'b0;
    cmd_half_period = PER_W'(50);
    cmd_valid       = 1'b1;
    n_acc  = 0;
    budget = 200;
    while (n_acc < 2 && budget > 0) begin
      @(negedge clk_50);
      if (cmd_ready) n_acc++;
      @(posedge clk_50);
      #1;
      budget--;
    end
    cmd_valid = 1'b0;
    check("zero_step_accepts", n_acc, 2);
    wait_idle(200);

    // reset asserted mid-LOW, between clock edges
    send_cmd(2, 1'b1, 60);
    wait_step(1'b1, 50);
    wait_step(1'b0, 100);
    repeat (10) @(posedge clk_50);
    #3 reset = 1'b1;
    #1;
    check_reset_outputs("midlow");
    repeat (2) @(posedge clk_50);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk_50);
    #1;

    // one step down from zero goes negative
    push_exp(11, 1, 50, 50, 111, 0, -1, 0, -1);
    send_cmd(1, 1'b0, 50);
    wait_idle(500);

    repeat (5) @(posedge clk_50);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
